// File: rtl/apb_master_nslv_if.sv
// apb_master_nslv_if
//   APB bus bundle between one master and NSLV slaves.
//   master modport: drives PADDR/PWDATA/PWRITE/PSEL/PENABLE and
//                   observes PREADY/PRDATA/PSLVERR.
//   slave modport : the mirror image, used by slave-side models.
//   Parameters AWIDTH/DWIDTH/NSLV must match the master instance.
//   PRDATA packs slave i at bits [i*DWIDTH +: DWIDTH].
interface apb_master_nslv_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int NSLV   = 4
);
  logic [AWIDTH-1:0]      PADDR;
  logic [DWIDTH-1:0]      PWDATA;
  logic                   PWRITE;
  logic [NSLV-1:0]        PSEL;
  logic                   PENABLE;
  logic [NSLV-1:0]        PREADY;
  logic [NSLV*DWIDTH-1:0] PRDATA;
  logic [NSLV-1:0]        PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_master_nslv.sv
// apb_master_nslv
//   APB master that turns a simple request strobe into one APB transfer
//   to one of NSLV slaves. The slave is chosen by the address field
//   ADDR_IN[SEL_LSB +: clog2(NSLV)]; an index with no slave behind it
//   completes with an error and never raises PSEL.
//
// Ports
//   PCLK, PRESETn        clock, asynchronous active-low reset
//   TRANSFER             request strobe, sampled in IDLE or on the
//                        completing ACCESS cycle (back-to-back)
//   WRITE_IN, ADDR_IN,
//   WDATA_IN             request attributes, captured with TRANSFER
//   RDATA                last read data (held across writes/errors)
//   DONE                 one-cycle completion pulse
//   ERR                  error flag, valid while DONE is high
//   BUSY                 high whenever the FSM is not in IDLE
//   bus                  APB bus (apb_master_nslv_if.master)
//
// Configuration
//   APB_MASTER_NSLV_TIMEOUT_EN  when defined, an ACCESS that sees
//   TIMEOUT non-ready cycles is abandoned and completes with ERR=1.
//   Without it ACCESS waits forever and TIMEOUT is ignored.
module apb_master_nslv #(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int NSLV    = 4,
  parameter int SEL_LSB = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              TRANSFER,
  input  logic              WRITE_IN,
  input  logic [AWIDTH-1:0] ADDR_IN,
  input  logic [DWIDTH-1:0] WDATA_IN,
  output logic [DWIDTH-1:0] RDATA,
  output logic              DONE,
  output logic              ERR,
  output logic              BUSY,
  apb_master_nslv_if.master bus
);

  localparam int SEL_W = (NSLV > 1) ? $clog2(NSLV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DERR
  } state_t;

  state_t           state;
  logic [SEL_W-1:0] sel_idx;
  logic [SEL_W-1:0] req_idx;
  logic             req_valid;
  logic             sel_ready;
  logic             sel_err;
  logic [DWIDTH-1:0] sel_rdata;
  logic             accept;

  assign req_idx = ADDR_IN[SEL_LSB +: SEL_W];

  // When NSLV is a power of two every index is populated, so the range
  // check collapses to a constant instead of a degenerate comparison.
  generate
    if (NSLV == (1 << SEL_W)) begin : g_full_decode
      assign req_valid = 1'b1;
    end else begin : g_part_decode
      assign req_valid = (req_idx < SEL_W'(NSLV));
    end
  endgenerate

  // Only the selected slave's response lines are ever looked at.
  assign sel_ready = bus.PREADY[sel_idx];
  assign sel_err   = bus.PSLVERR[sel_idx];
  assign sel_rdata = bus.PRDATA[int'(sel_idx) * DWIDTH +: DWIDTH];

  // A new request is taken from IDLE, or on the cycle an ACCESS completes
  // so that back-to-back transfers lose no cycle.
  assign accept = TRANSFER &&
                  ((state == ST_IDLE) || ((state == ST_ACCESS) && sel_ready));

`ifdef APB_MASTER_NSLV_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        timed_out;
  // wait_cnt holds the non-ready cycles already seen; the current one
  // is the TIMEOUT-th when the count equals TIMEOUT-1.
  assign timed_out = (wait_cnt == 16'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  // Single registered FSM. Completion actions are written in the case,
  // then a same-cycle accept overrides the next state and bus fields.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= ST_IDLE;
      sel_idx     <= '0;
      bus.PADDR   <= '0;
      bus.PWDATA  <= '0;
      bus.PWRITE  <= 1'b0;
      bus.PSEL    <= '0;
      bus.PENABLE <= 1'b0;
      RDATA       <= '0;
      DONE        <= 1'b0;
      ERR         <= 1'b0;
      BUSY        <= 1'b0;
`ifdef APB_MASTER_NSLV_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      DONE <= 1'b0;
      ERR  <= 1'b0;

      case (state)
        ST_IDLE: begin
          BUSY <= 1'b0;
        end

        ST_SETUP: begin
          state       <= ST_ACCESS;
          bus.PENABLE <= 1'b1;
        end

        ST_ACCESS: begin
          if (sel_ready) begin
            DONE <= 1'b1;
            ERR  <= sel_err;
            if (!bus.PWRITE) begin
              RDATA <= sel_rdata;
            end
            state       <= ST_IDLE;
            bus.PSEL    <= '0;
            bus.PENABLE <= 1'b0;
            BUSY        <= 1'b0;
          end
`ifdef APB_MASTER_NSLV_TIMEOUT_EN
          else if (timed_out) begin
            DONE        <= 1'b1;
            ERR         <= 1'b1;
            state       <= ST_IDLE;
            bus.PSEL    <= '0;
            bus.PENABLE <= 1'b0;
            BUSY        <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
`endif
        end

        ST_DERR: begin
          DONE  <= 1'b1;
          ERR   <= 1'b1;
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase

      if (accept) begin
        bus.PADDR   <= ADDR_IN;
        bus.PWDATA  <= WDATA_IN;
        bus.PWRITE  <= WRITE_IN;
        bus.PENABLE <= 1'b0;
        sel_idx     <= req_idx;
        BUSY        <= 1'b1;
`ifdef APB_MASTER_NSLV_TIMEOUT_EN
        wait_cnt    <= '0;
`endif
        if (req_valid) begin
          state    <= ST_SETUP;
          bus.PSEL <= NSLV'(1) << req_idx;
        end else begin
          state    <= ST_DERR;
          bus.PSEL <= '0;
        end
      end
    end
  end

endmodule
